// File: rtl/dds_pkg.sv
// dds_pkg: shared widths, quadrant codes and FSM state type for the DDS phase path
package dds_pkg;
  localparam int ACC_W_DEF = 32;
  localparam int PHASE_W_DEF = 12;
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/dds_quarter_fold.sv
// dds_quarter_fold: folds a full-wave phase into a quarter-wave LUT address and a sign
module dds_quarter_fold
  import dds_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF
) (
  input  logic [PHASE_W-1:0] i_phase,
  output logic [PHASE_W-3:0] o_addr,
  output logic               o_neg
);
  logic [1:0]         w_q;
  logic [PHASE_W-3:0] w_f;
  assign w_q = i_phase[PHASE_W-1:PHASE_W-2];
  assign w_f = i_phase[PHASE_W-3:0];
  // odd quadrants walk the quarter table backwards; the second half is negated
  always_comb begin
    o_addr = (w_q == Q1 || w_q == Q3) ? ~w_f : w_f;
    o_neg  = (w_q == Q2 || w_q == Q3);
  end
endmodule

// File: rtl/dds_phase_gen.sv
// dds_phase_gen: handshaked-FTW phase accumulator with offset and quarter-wave fold
module dds_phase_gen
  import dds_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF,
  localparam int ADDR_W = PHASE_W - 2
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic               Enable,
  input  logic [ACC_W-1:0]   FtwData,
  input  logic               FtwValid,
  output logic               FtwReady,
  input  logic [PHASE_W-1:0] PhaseOfs,
  output logic [ADDR_W-1:0]  LutAddr,
  output logic               LutNeg,
  output logic               AddrValid,
  output logic               Wrap,
  output logic               Running
);
  state_t              r_state, w_next;
  logic [ACC_W-1:0]    r_shadow, r_ftw, r_acc;
  logic                r_pend, r_carry;
  logic [PHASE_W-1:0]  r_ph1;
  logic                r_v1, r_c1;
  logic                w_accept;
  logic [ACC_W:0]      w_sum;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_neg;

  assign w_accept = FtwValid && !r_pend;
  assign w_sum    = {1'b0, r_acc} + {1'b0, r_ftw};
  assign FtwReady = !r_pend;
  assign Running  = (r_state == RUN);

  // Enable level alone decides the next state from either state
  always_comb begin
    w_next = r_state;
    w_next = Enable ? RUN : IDLE;
  end

  // state register
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) r_state <= IDLE;
    else r_state <= w_next;
  end

  // accepted word waits one cycle in the shadow before becoming active
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_shadow <= '0;
      r_ftw    <= '0;
      r_pend   <= 1'b0;
    end else if (w_accept) begin
      r_shadow <= FtwData;
      r_pend   <= 1'b1;
    end else if (r_pend) begin
      r_ftw  <= r_shadow;
      r_pend <= 1'b0;
    end
  end

  // accumulate only while staying in RUN; carry travels alongside the wrapped value
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else if (r_state == RUN && Enable) begin
      {r_carry, r_acc} <= w_sum;
    end else begin
      r_acc   <= '0;
      r_carry <= 1'b0;
    end
  end

  // stage 1: truncate, add offset, tag validity and wrap
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_ph1 <= '0;
      r_v1  <= 1'b0;
      r_c1  <= 1'b0;
    end else begin
      r_ph1 <= r_acc[ACC_W-1 -: PHASE_W] + PhaseOfs;
      r_v1  <= (r_state == RUN);
      r_c1  <= r_carry;
    end
  end

  dds_quarter_fold #(.PHASE_W(PHASE_W)) u_fold (
    .i_phase(r_ph1),
    .o_addr (w_addr),
    .o_neg  (w_neg)
  );

  // stage 2: register the fold; address and sign hold while no valid sample
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      LutAddr   <= '0;
      LutNeg    <= 1'b0;
      AddrValid <= 1'b0;
      Wrap      <= 1'b0;
    end else begin
      if (r_v1) begin
        LutAddr <= w_addr;
        LutNeg  <= w_neg;
      end
      AddrValid <= r_v1;
      Wrap      <= r_v1 && r_c1;
    end
  end
endmodule

// File: tb/tb_dds_phase_gen.sv
// tb_dds_phase_gen: directed self-checking bench for the DDS phase generator
`timescale 1ns/1ps
module tb_dds_phase_gen;
  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        Enable = 1'b0;
  logic [31:0] FtwData = '0;
  logic        FtwValid = 1'b0;
  logic [11:0] PhaseOfs = '0;
  logic        FtwReady, LutNeg, AddrValid, Wrap, Running;
  logic [9:0]  LutAddr;
  int checks = 0;
  int failures = 0;

  always #18.5 CLK = ~CLK;

  dds_phase_gen dut (
    .CLK(CLK), .RESETn(RESETn), .Enable(Enable), .FtwData(FtwData),
    .FtwValid(FtwValid), .FtwReady(FtwReady), .PhaseOfs(PhaseOfs),
    .LutAddr(LutAddr), .LutNeg(LutNeg), .AddrValid(AddrValid),
    .Wrap(Wrap), .Running(Running)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int addr, input bit neg, input bit wrap, input bit valid);
    chk({tag, ".addr"}, 32'(LutAddr), 32'(addr));
    chk({tag, ".neg"}, 32'(LutNeg), 32'(neg));
    chk({tag, ".wrap"}, 32'(Wrap), 32'(wrap));
    chk({tag, ".valid"}, 32'(AddrValid), 32'(valid));
  endtask

  task automatic load(input logic [31:0] w);
    FtwData = w;
    FtwValid = 1'b1;
    tick(1);
    FtwValid = 1'b0;
    tick(1);
  endtask

  int exp_a[6] = '{1023, 0, 512, 1023, 511, 0};
  bit exp_n[6] = '{1, 0, 0, 0, 0, 1};
  bit exp_w[6] = '{0, 1, 0, 0, 0, 0};

  initial begin
    tick(10);
    chk_out("reset", 0, 0, 0, 0);
    chk("reset.running", 32'(Running), 0);
    chk("reset.ready", 32'(FtwReady), 1);
    RESETn = 1'b1;
    tick(1);
    FtwData = 32'h4000_0000;
    FtwValid = 1'b1;
    tick(1);
    chk("t1.ready_low", 32'(FtwReady), 0);
    FtwValid = 1'b0;
    tick(1);
    chk("t1.ready_back", 32'(FtwReady), 1);
    Enable = 1'b1;
    tick(1);
    chk("t2.running", 32'(Running), 1);
    chk("t2.valid_k", 32'(AddrValid), 0);
    tick(1);
    chk("t2.valid_k1", 32'(AddrValid), 0);
    tick(1);
    chk_out("t1.s0", 0, 0, 0, 1);
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      chk_out($sformatf("t1.s%0d", i), (i % 2) ? 1023 : 0, (i % 4) >= 2, (i % 4) == 0, 1);
    end
    Enable = 1'b0;
    tick(1);
    chk("t2.running_off", 32'(Running), 0);
    chk_out("t2.m", 1023, 0, 0, 1);
    tick(1);
    chk_out("t2.m1", 0, 1, 0, 1);
    tick(1);
    chk_out("t2.m2", 0, 1, 0, 0);
    tick(1);
    chk_out("t2.hold", 0, 1, 0, 0);
    Enable = 1'b1;
    tick(3);
    chk_out("t3.s0", 0, 0, 0, 1);
    FtwData = 32'h2000_0000;
    FtwValid = 1'b1;
    tick(1);
    chk("t3.ready_low", 32'(FtwReady), 0);
    chk_out("t3.a", 1023, 0, 0, 1);
    FtwData = 32'h1234_5678;
    tick(1);
    chk("t3.ready_high", 32'(FtwReady), 1);
    chk_out("t3.a1", 0, 1, 0, 1);
    FtwValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk_out($sformatf("t3.a%0d", i + 2), exp_a[i], exp_n[i], exp_w[i], 1);
    end
    Enable = 1'b0;
    tick(3);
    load(32'h0);
    PhaseOfs = 12'h400;
    Enable = 1'b1;
    tick(3);
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("t4.s%0d", i), 1023, 0, 0, 1);
      tick(1);
    end
    load(32'h4000_0000);
    tick(3);
    #5 RESETn = 1'b0;
    #1;
    chk_out("t5.async", 0, 0, 0, 0);
    chk("t5.running", 32'(Running), 0);
    chk("t5.ready", 32'(FtwReady), 1);
    PhaseOfs = '0;
    @(posedge CLK);
    #1 RESETn = 1'b1;
    tick(1);
    chk("t5.running_again", 32'(Running), 1);
    tick(2);
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("t5.s%0d", i), 0, 0, 0, 1);
      tick(1);
    end
    FtwData = 32'hFFFF_FFFF;
    FtwValid = 1'b1;
    tick(1);
    FtwValid = 1'b0;
    tick(2);
    chk_out("t6.a2", 0, 0, 0, 1);
    tick(1);
    chk_out("t6.a3", 0, 0, 0, 1);
    tick(1);
    chk_out("t6.first", 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk_out($sformatf("t6.w%0d", i), 0, 1, 1, 1);
    end
    Enable = 1'b0;
    tick(1);
    chk("t6.running_off", 32'(Running), 0);
    tick(2);
    chk_out("t6.stop", 0, 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dds_phase_gen.md
# dds_phase_gen

Phase-generation stage of the DDS signal path, directly downstream of the reset generator. Its asynchronous reset input is the generator's function-generator reset, so it starts only after the external reset is released and the PLL has locked. It runs a phase accumulator driven by a handshaked frequency tuning word (FTW) and adds a phase offset. It then folds the phase into a quarter-wave LUT address plus sign, which feed the sine LUT and DAC stages.

## Interface
Parameters:
- ACC_W, 32: accumulator and FTW width.
- PHASE_W, 12: truncated phase width (≥ 4).
- ADDR_W, PHASE_W-2: quarter-wave LUT address width. Derived; not overridable.

Ports:
- CLK  in  1  system clock, 27 MHz.
- RESETn  in  1  reset, asynchronous, active-low. Driven by the function-generator reset.
- Enable  in  1  level; 1 = run, 0 = stop and clear the accumulator.
- FtwData  in  ACC_W  new tuning word.
- FtwValid  in  1  FtwData is valid.
- FtwReady  out  1  block can accept an FTW.
- PhaseOfs  in  PHASE_W  phase offset, sampled every cycle.
- LutAddr  out  ADDR_W  quarter-wave LUT address.
- LutNeg  out  1  LUT output must be negated (phase in 2nd half).
- AddrValid  out  1  LutAddr/LutNeg hold a valid sample.
- Wrap  out  1  one-cycle pulse on the sample where the accumulator wrapped.
- Running  out  1  FSM is in RUN.

## Operation
- Two states.
  - IDLE: accumulator is 0 and no valid samples are produced. Moves to RUN at the edge where Enable = 1.
  - RUN: accumulator advances each cycle. Moves to IDLE at the edge where Enable = 0; the accumulator clears to 0 at that same edge.
- FTW path:
  - Transfer happens when FtwValid && FtwReady. FtwData goes into a shadow register, and a pending flag sets.
  - FtwReady = !pending.
  - On the next edge, shadow copies to the active FTW and pending clears. Ready is therefore low for exactly one cycle after each accept. The copy happens in both IDLE and RUN.
  - The active FTW resets to 0.
- Accumulator, in RUN: acc <= acc + ftw_active, modulo 2^ACC_W. The carry-out is the wrap event.
- Stage 1 (registered):
  - ph1 <= acc[ACC_W-1 -: PHASE_W] + PhaseOfs, modulo 2^PHASE_W.
  - v1 <= (state == RUN).
  - The carry-out of the acc update is delayed so it is tagged to the sample containing the wrapped value.
- Stage 2 (registered fold):
  - q = ph1[PHASE_W-1:PHASE_W-2]; f = ph1[PHASE_W-3:0].
  - LutAddr <= q[0] ? ~f : f.
  - LutNeg <= q[1].
  - AddrValid <= v1.
  - Wrap <= the carry tag for this sample, gated by v1.
- Outputs hold their last values when AddrValid = 0.
- Reset values: all outputs 0 (FtwReady = 1). Accumulator, shadow, active FTW and pending are all 0. State is IDLE.

## Timing
- Enable sampled 1 at edge k:
  - Running = 1 after k.
  - At k+1: ph1 holds the acc = 0 sample, and acc = ftw_active.
  - At k+2: first AddrValid = 1 (sample for phase 0 + PhaseOfs).
  - Latency from the Enable edge to the first valid sample is 2 cycles.
- Enable sampled 0 at edge m: Running = 0 and acc = 0 after m. AddrValid goes low after m+2; the last valid sample is the one captured at m.
- FTW accepted at edge a: ftw_active is updated at a+1, and the first increment using it is at a+2.
- FtwValid high while pending: no accept. Upstream must hold the data until it sees FtwReady.
- Wrap is asserted in the same cycle AddrValid presents the first sample after the carry.
- RESETn assertion mid-run: asynchronous clear of everything. AddrValid drops immediately. No sample or FTW survives.

## Structure
- Package dds_pkg holds:
  - ACC_W and PHASE_W defaults.
  - Quadrant constants Q0–Q3.
  - FSM state enum {IDLE, RUN}.
- Sub-module dds_quarter_fold: combinational q/f fold producing address and sign. It is reused by the cosine channel later; the parent registers its outputs.

## Test plan
Defaults are used throughout; CLK is 27 MHz.

1. Reset then run:
   - Stimulus: RESETn low for 10 cycles, FTW = 0x40000000 loaded, Enable = 1.
   - Required: LutAddr/LutNeg repeat (0,0), (1023,0), (0,1), (1023,1). Wrap = 1 on every 4th sample (the acc = 0 one).
2. Start latency:
   - Stimulus: Enable rising edge.
   - Required: AddrValid rises exactly 2 cycles later. On Enable fall, AddrValid falls exactly 2 cycles later.
3. Handshake:
   - Stimulus: FtwValid held high with FTW = 0x20000000 during the run.
   - Required: FtwReady is low for 1 cycle. The step changes to 512 addresses per sample starting 2 cycles after the accept. A second FtwValid during pending is ignored.
4. Offset:
   - Stimulus: PhaseOfs = 0x400 with FTW = 0.
   - Required: constant LutAddr = 1023, LutNeg = 0, no Wrap.
5. Reset mid-run:
   - Stimulus: RESETn pulsed low for 1 cycle while running.
   - Required: all outputs are 0 immediately and the active FTW is 0. After release with Enable = 1, the output stays at address 0 until a new FTW is loaded.
6. Wrap edge case:
   - Stimulus: FTW = 0xFFFFFFFF.
   - Required: Wrap is asserted on every valid sample except the first. The phase decreases by 1 LSB of acc per cycle.
